// File: rtl/vscale_csr_counter_bank.sv
// Event-driven hardware performance counter bank with CSR access, per-counter
// event select, inhibit mask and sticky overflow status driving a level interrupt.
module vscale_csr_counter_bank #(
  parameter int unsigned XPR_LEN   = 32,
  parameter int unsigned N_CNT     = 4,
  parameter int unsigned CNT_WIDTH = 64,
  parameter int unsigned N_EVENTS  = 8
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic [11:0]         i_addr,
  input  logic [2:0]          i_cmd,
  input  logic [XPR_LEN-1:0]  i_wdata,
  output logic [XPR_LEN-1:0]  o_rdata,
  output logic                o_hit,
  input  logic [N_EVENTS-1:0] i_events,
  output logic                o_ovf_irq
);

  localparam int unsigned HI_W = CNT_WIDTH - 32;

  localparam logic [11:0] A_CNT_LO = 12'hB03;
  localparam logic [11:0] A_CNT_HI = 12'hB83;
  localparam logic [11:0] A_SEL    = 12'h323;
  localparam logic [11:0] A_INH    = 12'h320;
  localparam logic [11:0] A_OVF    = 12'h7C0;

  localparam logic [2:0] CMD_WRITE = 3'd5;
  localparam logic [2:0] CMD_SET   = 3'd6;
  localparam logic [2:0] CMD_CLR   = 3'd7;

  logic [N_CNT-1:0][CNT_WIDTH-1:0] r_cnt;
  logic [N_CNT-1:0][7:0]           r_sel;
  logic [N_CNT-1:0]                r_ie;
  logic [N_CNT-1:0]                r_inh;
  logic [N_CNT-1:0]                r_ovf;

  logic [255:0]       w_ev_pad;
  logic [N_CNT-1:0]   w_inc;
  logic [N_CNT-1:0]   w_wrap;
  logic [N_CNT-1:0]   w_wr_lo;
  logic [N_CNT-1:0]   w_wr_hi;
  logic [N_CNT-1:0]   w_wr_sel;
  logic [N_CNT-1:0]   w_cnt_wr;
  logic               w_wr_inh;
  logic               w_wr_ovf;
  logic               w_wr_cmd;
  logic [31:0]        w_rd32;
  logic [31:0]        w_inh_word;
  logic [31:0]        w_ovf_word;
  logic [XPR_LEN-1:0] w_wval;

  // Bit 0 is SEL=0 (never counts); SEL values above N_EVENTS land on zero padding.
  assign w_ev_pad = 256'({i_events, 1'b0});
  assign w_wr_cmd = (i_cmd == CMD_WRITE) || (i_cmd == CMD_SET) || (i_cmd == CMD_CLR);

  // Address decode, read mux and per-register write strobes
  always_comb begin : decode
    w_inh_word = '0;
    w_ovf_word = '0;
    w_rd32     = '0;
    o_hit      = 1'b0;
    w_wr_lo    = '0;
    w_wr_hi    = '0;
    w_wr_sel   = '0;
    w_wr_inh   = 1'b0;
    w_wr_ovf   = 1'b0;
    for (int i = 0; i < N_CNT; i++) begin
      w_inh_word[3+i] = r_inh[i];
      w_ovf_word[3+i] = r_ovf[i];
    end
    for (int i = 0; i < N_CNT; i++) begin
      if (i_addr == A_CNT_LO + 12'(i)) begin
        o_hit      = 1'b1;
        w_rd32     = r_cnt[i][31:0];
        w_wr_lo[i] = w_wr_cmd;
      end
      if (i_addr == A_CNT_HI + 12'(i)) begin
        o_hit      = 1'b1;
        w_rd32     = 32'(r_cnt[i][CNT_WIDTH-1:32]);
        w_wr_hi[i] = w_wr_cmd;
      end
      if (i_addr == A_SEL + 12'(i)) begin
        o_hit       = 1'b1;
        w_rd32      = {r_ie[i], 23'd0, r_sel[i]};
        w_wr_sel[i] = w_wr_cmd;
      end
    end
    if (i_addr == A_INH) begin
      o_hit    = 1'b1;
      w_rd32   = w_inh_word;
      w_wr_inh = w_wr_cmd;
    end
    if (i_addr == A_OVF) begin
      o_hit    = 1'b1;
      w_rd32   = w_ovf_word;
      w_wr_ovf = w_wr_cmd;
    end
  end

  assign o_rdata = XPR_LEN'(w_rd32);

  // Write operand: plain write, set or clear relative to current read value
  always_comb begin : wval
    w_wval = i_wdata;
    case (i_cmd)
      CMD_SET: w_wval = o_rdata | i_wdata;
      CMD_CLR: w_wval = o_rdata & ~i_wdata;
      default: w_wval = i_wdata;
    endcase
  end

  // A CSR write to a counter word suppresses that counter's increment and wrap
  always_comb begin : count_ctl
    w_inc    = '0;
    w_wrap   = '0;
    w_cnt_wr = '0;
    for (int i = 0; i < N_CNT; i++) begin
      w_cnt_wr[i] = w_wr_lo[i] | w_wr_hi[i];
      w_inc[i]    = w_ev_pad[r_sel[i]] & ~r_inh[i];
      w_wrap[i]   = w_inc[i] & ~w_cnt_wr[i] & (&r_cnt[i]);
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_cnt <= '0;
      r_sel <= '0;
      r_ie  <= '0;
      r_inh <= '0;
      r_ovf <= '0;
    end else begin
      for (int i = 0; i < N_CNT; i++) begin
        if (w_cnt_wr[i]) begin
          if (w_wr_lo[i]) r_cnt[i][31:0] <= w_wval[31:0];
          if (w_wr_hi[i]) r_cnt[i][CNT_WIDTH-1:32] <= w_wval[HI_W-1:0];
        end else if (w_inc[i]) begin
          r_cnt[i] <= r_cnt[i] + CNT_WIDTH'(1);
        end
        if (w_wr_sel[i]) begin
          r_sel[i] <= w_wval[7:0];
          r_ie[i]  <= w_wval[31];
        end
        if (w_wr_inh) r_inh[i] <= w_wval[3+i];
        // Hardware overflow set wins over a software write of the same bit
        if (w_wrap[i])     r_ovf[i] <= 1'b1;
        else if (w_wr_ovf) r_ovf[i] <= w_wval[3+i];
      end
    end
  end

  assign o_ovf_irq = |(r_ovf & r_ie);

endmodule

// File: tb/tb_vscale_csr_counter_bank.sv
// Bench for vscale_csr_counter_bank: vector table with a scoreboard queue on the
// default instance, plus hand sequences for a narrow instance and async reset.
module tb_vscale_csr_counter_bank;

  localparam logic [11:0] B03 = 12'hB03;
  localparam logic [11:0] B04 = 12'hB04;
  localparam logic [11:0] B83 = 12'hB83;
  localparam logic [11:0] B84 = 12'hB84;
  localparam logic [11:0] SEL0 = 12'h323;
  localparam logic [11:0] SEL1 = 12'h324;
  localparam logic [11:0] INH = 12'h320;
  localparam logic [11:0] OVF = 12'h7C0;
  localparam logic [2:0] CI = 3'd0;
  localparam logic [2:0] CR = 3'd4;
  localparam logic [2:0] CW = 3'd5;
  localparam logic [2:0] CS = 3'd6;
  localparam logic [2:0] CC = 3'd7;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  a_cmd, b_cmd;
  logic [11:0] a_addr, b_addr;
  logic [31:0] a_wdata, b_wdata, a_rdata, b_rdata;
  logic [7:0]  a_events, b_events;
  logic        a_hit, b_hit, a_irq, b_irq;

  always #5 clk = ~clk;

  vscale_csr_counter_bank dut (
    .i_clk(clk), .i_reset(rst), .i_addr(a_addr), .i_cmd(a_cmd), .i_wdata(a_wdata),
    .o_rdata(a_rdata), .o_hit(a_hit), .i_events(a_events), .o_ovf_irq(a_irq)
  );

  vscale_csr_counter_bank #(.XPR_LEN(32), .N_CNT(2), .CNT_WIDTH(40), .N_EVENTS(8)) dut2 (
    .i_clk(clk), .i_reset(rst), .i_addr(b_addr), .i_cmd(b_cmd), .i_wdata(b_wdata),
    .o_rdata(b_rdata), .o_hit(b_hit), .i_events(b_events), .o_ovf_irq(b_irq)
  );

  typedef struct packed {
    logic [2:0]  cmd;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [7:0]  ev;
    logic [11:0] chk;
    logic [31:0] exp_rd;
    logic        exp_hit;
    logic        exp_irq;
  } vec_t;

  typedef struct packed {
    logic [15:0] idx;
    logic [31:0] rd;
    logic        hit;
    logic        irq;
  } sb_t;

  vec_t vecs[$];
  sb_t  sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic add(input logic [2:0] cmd, input logic [11:0] addr, input logic [31:0] wd,
                     input logic [7:0] ev, input logic [11:0] chk, input logic [31:0] rd,
                     input logic hit, input logic irq);
    vec_t v;
    v.cmd = cmd; v.addr = addr; v.wdata = wd; v.ev = ev;
    v.chk = chk; v.exp_rd = rd; v.exp_hit = hit; v.exp_irq = irq;
    vecs.push_back(v);
  endtask

  task automatic rd1(input logic [11:0] addr, input logic [31:0] exp, input logic hit,
                     input logic irq, input string nm);
    a_cmd = CR; a_addr = addr; #1;
    check({nm, ".rdata"}, a_rdata, exp);
    check({nm, ".hit"}, 32'(a_hit), 32'(hit));
    check({nm, ".irq"}, 32'(a_irq), 32'(irq));
  endtask

  task automatic rd2(input logic [11:0] addr, input logic [31:0] exp, input logic hit,
                     input logic irq, input string nm);
    b_cmd = CR; b_addr = addr; #1;
    check({nm, ".rdata"}, b_rdata, exp);
    check({nm, ".hit"}, 32'(b_hit), 32'(hit));
    check({nm, ".irq"}, 32'(b_irq), 32'(irq));
  endtask

  task automatic step2(input logic [2:0] cmd, input logic [11:0] addr, input logic [31:0] wd,
                       input logic [7:0] ev);
    @(negedge clk);
    b_cmd = cmd; b_addr = addr; b_wdata = wd; b_events = ev;
    @(posedge clk); #1;
    b_cmd = CI; b_events = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    sb_t e;
    rst = 1'b1;
    a_cmd = CI; a_addr = '0; a_wdata = '0; a_events = '0;
    b_cmd = CI; b_addr = '0; b_wdata = '0; b_events = '0;

    // {cmd, addr, wdata, events, read-back addr, rdata, hit, irq}, one clock edge each
    add(CI, 0, 0, 0, B03, 0, 1, 0);
    add(CI, 0, 0, 0, B83, 0, 1, 0);
    add(CI, 0, 0, 0, SEL0, 0, 1, 0);
    add(CI, 0, 0, 0, INH, 0, 1, 0);
    add(CI, 0, 0, 0, OVF, 0, 1, 0);
    add(CW, SEL0, 32'h8000_0001, 0, SEL0, 32'h8000_0001, 1, 0);
    for (int k = 1; k <= 10; k++) add(CI, 0, 0, 8'h01, B03, 32'(k), 1, 0);
    add(CS, INH, 32'h8, 0, INH, 32'h8, 1, 0);
    add(CI, 0, 0, 8'h01, B03, 32'd10, 1, 0);
    add(CI, 0, 0, 8'hFF, B03, 32'd10, 1, 0);
    add(CC, INH, 32'h8, 0, INH, 0, 1, 0);
    add(CI, 0, 0, 8'h01, B03, 32'd11, 1, 0);
    add(CW, B03, 32'd5, 0, B03, 32'd5, 1, 0);
    add(CW, B03, 32'h100, 8'h01, B03, 32'h100, 1, 0);
    add(CI, 0, 0, 8'h01, B03, 32'h101, 1, 0);
    add(CW, B83, 32'h1234_5678, 8'h01, B03, 32'h101, 1, 0);
    add(CI, 0, 0, 0, B83, 32'h1234_5678, 1, 0);
    add(CW, B03, 32'hAAAA_5555, 0, B83, 32'h1234_5678, 1, 0);
    add(CW, B83, 32'hFFFF_FFFF, 0, B83, 32'hFFFF_FFFF, 1, 0);
    add(CW, B03, 32'hFFFF_FFFE, 0, B03, 32'hFFFF_FFFE, 1, 0);
    add(CI, 0, 0, 8'h01, B03, 32'hFFFF_FFFF, 1, 0);
    add(CI, 0, 0, 8'h01, B03, 0, 1, 1);
    add(CI, 0, 0, 0, B83, 0, 1, 1);
    add(CI, 0, 0, 0, OVF, 32'h8, 1, 1);
    add(CC, OVF, 32'h8, 0, OVF, 0, 1, 0);
    add(CW, B03, 32'hFFFF_FFFF, 0, B03, 32'hFFFF_FFFF, 1, 0);
    add(CW, B83, 32'hFFFF_FFFF, 0, B83, 32'hFFFF_FFFF, 1, 0);
    add(CW, OVF, 32'h0, 8'h01, OVF, 32'h8, 1, 1);
    add(CI, 0, 0, 0, B03, 0, 1, 1);
    add(CC, OVF, 32'hFFFF_FFFF, 0, OVF, 0, 1, 0);
    add(CW, SEL0, 32'h8000_0009, 0, SEL0, 32'h8000_0009, 1, 0);
    add(CI, 0, 0, 8'hFF, B03, 0, 1, 0);
    add(CW, SEL0, 32'h8000_0000, 0, SEL0, 32'h8000_0000, 1, 0);
    add(CI, 0, 0, 8'hFF, B03, 0, 1, 0);
    add(CW, SEL0, 32'h8000_0008, 0, SEL0, 32'h8000_0008, 1, 0);
    add(CI, 0, 0, 8'h7F, B03, 0, 1, 0);
    add(CI, 0, 0, 8'h80, B03, 32'd1, 1, 0);
    add(CW, SEL0, 32'hFFFF_FFFF, 0, SEL0, 32'h8000_00FF, 1, 0);
    add(CI, 0, 0, 8'hFF, B03, 32'd1, 1, 0);
    add(CW, INH, 32'hFFFF_FFFF, 0, INH, 32'h78, 1, 0);
    add(CW, INH, 32'h0, 0, INH, 0, 1, 0);
    add(CW, SEL1, 32'h2, 0, SEL1, 32'h2, 1, 0);
    add(CW, SEL0, 32'h8000_0001, 0, SEL0, 32'h8000_0001, 1, 0);
    add(CI, 0, 0, 8'h03, B03, 32'd2, 1, 0);
    add(CI, 0, 0, 0, B04, 32'd1, 1, 0);
    add(CW, B04, 32'hFFFF_FFFF, 0, B04, 32'hFFFF_FFFF, 1, 0);
    add(CW, B84, 32'hFFFF_FFFF, 0, B84, 32'hFFFF_FFFF, 1, 0);
    add(CI, 0, 0, 8'h03, OVF, 32'h10, 1, 0);
    add(CI, 0, 0, 0, B04, 0, 1, 0);
    add(CS, SEL1, 32'h8000_0000, 0, SEL1, 32'h8000_0002, 1, 1);
    add(CC, OVF, 32'h10, 0, OVF, 0, 1, 0);
    add(CW, 12'hB07, 32'h1234, 0, 12'hB07, 0, 0, 0);
    add(CI, 0, 0, 0, 12'h321, 0, 0, 0);
    add(CW, 12'hB87, 32'h5678, 0, 12'hB87, 0, 0, 0);
    add(CI, 0, 0, 0, B03, 32'd3, 1, 0);
    add(CR, B03, 32'hFFFF, 0, B03, 32'd3, 1, 0);
    add(CI, B03, 32'hFFFF, 0, B03, 32'd3, 1, 0);
    add(CI, 0, 0, 0, 12'hB86, 0, 1, 0);

    #12;
    rd1(B03, 0, 1, 0, "in_reset");
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[k]) begin
      @(negedge clk);
      a_cmd = vecs[k].cmd; a_addr = vecs[k].addr;
      a_wdata = vecs[k].wdata; a_events = vecs[k].ev;
      sb.push_back('{idx: 16'(k), rd: vecs[k].exp_rd, hit: vecs[k].exp_hit, irq: vecs[k].exp_irq});
      @(posedge clk); #1;
      a_cmd = CR; a_events = '0; a_addr = vecs[k].chk;
      #1;
      e = sb.pop_front();
      check($sformatf("vec%0d.rdata", e.idx), a_rdata, e.rd);
      check($sformatf("vec%0d.hit", e.idx), 32'(a_hit), 32'(e.hit));
      check($sformatf("vec%0d.irq", e.idx), 32'(a_irq), 32'(e.irq));
    end
    check("sb_drained", 32'(sb.size()), 32'd0);

    // Narrow instance: two counters, 40-bit width
    step2(CW, 12'hB05, 32'h1234, 0);
    rd2(12'hB05, 0, 0, 0, "n2_lo_unimpl");
    rd2(B03, 0, 1, 0, "n2_lo0_untouched");
    step2(CW, 12'hB85, 32'hFFFF_FFFF, 0);
    rd2(12'hB85, 0, 0, 0, "n2_hi_unimpl");
    rd2(B84, 0, 1, 0, "n2_hi1_untouched");
    step2(CW, SEL0, 32'h8000_0001, 0);
    step2(CW, B83, 32'hFFFF_FFFF, 0);
    rd2(B83, 32'h0000_00FF, 1, 0, "n2_hi_trunc");
    step2(CW, B03, 32'hFFFF_FFFF, 0);
    step2(CI, 0, 0, 8'h01);
    rd2(B03, 0, 1, 1, "n2_wrap_lo");
    rd2(B83, 0, 1, 1, "n2_wrap_hi");
    rd2(OVF, 32'h8, 1, 1, "n2_wrap_ovf");

    // Asynchronous reset between edges while counting, then with a write pending
    @(negedge clk);
    a_cmd = CI; a_events = 8'h01;
    @(posedge clk); #2;
    rst = 1'b1;
    rd1(B03, 0, 1, 0, "arst_cnt");
    rd1(SEL0, 0, 1, 0, "arst_sel");
    @(negedge clk);
    a_cmd = CW; a_addr = B03; a_wdata = 32'h55; a_events = 8'h01;
    @(posedge clk); #2;
    rst = 1'b0;
    a_addr = SEL0; a_wdata = 32'h8000_0001;
    @(posedge clk); #1;
    rd1(B03, 0, 1, 0, "arst_write_dropped");
    rd1(SEL0, 32'h8000_0001, 1, 0, "arst_first_edge_sel");
    @(posedge clk); #1;
    rd1(B03, 32'd1, 1, 0, "arst_count1");
    @(posedge clk); #1;
    rd1(B03, 32'd2, 1, 0, "arst_count2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vscale_csr_counter_bank.md
VSCALE_CSR_COUNTER_BANK -- requirements
Module: vscale_csr_counter_bank

Interface
REQ-001 Parameter XPR_LEN, default 32, CSR data width.
REQ-002 Parameter N_CNT, default 4, number of counters, legal range 1..29.
REQ-003 Parameter CNT_WIDTH, default 64, counter width, legal range 33..64.
REQ-004 Parameter N_EVENTS, default 8, number of event inputs, legal range 1..255.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 addr  input  12  CSR address.
REQ-008 cmd  input  3  CSR command: 0 idle, 4 read, 5 write, 6 set, 7 clear.
REQ-009 wdata  input  XPR_LEN  CSR write operand.
REQ-010 rdata  output  XPR_LEN  combinational read data for addr.
REQ-011 hit  output  1  addr decodes to an implemented register of this block.
REQ-012 events  input  N_EVENTS  per-cycle event pulses, one count per high cycle.
REQ-013 ovf_irq  output  1  level overflow interrupt request.

Function
REQ-014 Counter i (0..N_CNT-1) SHALL be read and written as a low word at 0xB03+i and a high word at 0xB83+i.
REQ-015 Event select register i SHALL be at 0x323+i: bits[7:0] SEL, bit 31 IE, other bits read 0.
REQ-016 The inhibit register SHALL be at 0x320: bit 3+i inhibits counter i, other bits read 0.
REQ-017 The overflow status register SHALL be at 0x7C0: bit 3+i is OVF of counter i, other bits read 0.
REQ-018 Addresses of counters with i >= N_CNT, or any other address, SHALL give hit=0 and rdata=0, and writes to them SHALL be ignored.
REQ-019 Write data: cmd 5 writes wdata; cmd 6 writes rdata|wdata; cmd 7 writes rdata&~wdata.
REQ-020 Commands 0 and 4 SHALL NOT modify any state.
REQ-021 Counter i SHALL increment by 1 in a cycle when SEL in 1..N_EVENTS, events[SEL-1]=1, and the inhibit bit is 0.
REQ-022 SEL=0 or SEL>N_EVENTS SHALL never count.
REQ-023 High-word reads SHALL return counter[CNT_WIDTH-1:32], zero-extended to XPR_LEN.
REQ-024 Writes SHALL update only implemented bits; high-word bits at or above CNT_WIDTH SHALL be discarded.
REQ-025 Wrap SHALL occur when the counter is all ones (CNT_WIDTH bits) and increments: the counter becomes 0 and OVF is set on the same edge.
REQ-026 A CSR write to either word of counter i SHALL take priority over its increment in the same cycle; that increment is lost and no OVF is set.
REQ-027 A write to the low word SHALL preserve the high bits, and a write to the high word SHALL preserve the low bits.
REQ-028 Hardware OVF set SHALL take priority over a software write or clear of that bit in the same cycle.
REQ-029 ovf_irq SHALL equal OR over i of (OVF[i] & IE[i]), driven from registered state with no combinational path from events.
REQ-030 Increments and writes SHALL be visible in rdata the cycle after the edge.
REQ-031 ovf_irq SHALL assert the cycle after the wrapping edge.
REQ-032 All counters SHALL count independently; any number may increment or wrap in one cycle.

Reset
REQ-033 Reset assertion SHALL asynchronously clear all counters, SEL, IE, inhibit and OVF; ovf_irq=0 immediately.
REQ-034 Reset mid-count or mid-write SHALL discard the in-flight update.
REQ-035 On the first rising edge after reset deassertion, normal operation SHALL resume with no update lost or duplicated.

Verification
V-1 Reset; read 0xB03, 0xB83, 0x323, 0x320 and 0x7C0 -> all 0, hit=1, ovf_irq=0.
V-2 Write 0x323=0x80000001; hold events[0]=1 for 10 cycles -> 0xB03 reads 10; set 0x320 bit 3 -> count freezes at that value.
V-3 Write 0xB83=0xFFFFFFFF and 0xB03=0xFFFFFFFE; two events -> counter reads 0/0, OVF bit 3=1, ovf_irq=1 one cycle after wrap; cmd 7 to 0x7C0 with wdata 0x8 -> ovf_irq=0.
V-4 Counter at 5 with an event present; cmd 5 to 0xB03 with 0x100 in the same cycle -> next read 0x100, not 0x101.
V-5 N_CNT=2; access 0xB05 -> hit=0, rdata=0, no state change. CNT_WIDTH=40; write 0xB83=0xFFFFFFFF -> reads 0x000000FF.
V-6 Assert reset asynchronously between edges while counting -> all state 0 before the next edge; first edge after deassertion counts from 0.
